// File: rtl/td4_clock_ctrl.sv
// Execution-clock controller for the TD4 CPU: derives a one-cycle advance enable
// from a slow/fast prescaler or a debounced single-step button, plus heartbeat and step count.
module td4_clock_ctrl #(
    parameter int SLOW_DIV        = 50_000_000,
    parameter int FAST_DIV        = 5_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       step_btn,
    output logic       cpu_en,
    output logic       beat,
    output logic [7:0] step_cnt
);

    localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int PW      = $clog2(MAX_DIV);
    localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_DIV - 1);
    localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_SLOW = 2'b01,
        MODE_FAST = 2'b10,
        MODE_STEP = 2'b11
    } mode_t;

    logic [1:0]    mode_meta_r;
    mode_t         mode_sync_r;
    logic          btn_meta_r;
    logic          btn_sync_r;
    logic          btn_level_r;
    logic          btn_level_prev_r;
    logic [DW-1:0] db_cnt_r;
    logic [PW-1:0] presc_r;
    logic          cpu_en_r;
    logic          beat_r;
    logic [7:0]    step_cnt_r;

    logic          mode_change_s;
    logic          auto_s;
    logic [PW-1:0] div_last_s;
    logic          presc_wrap_s;
    logic          step_rise_s;
    logic          req_s;

    // Pulse request: mode_meta_r is what mode_sync_r becomes on this edge, so a
    // difference means the next cycle is a mode-change cycle with a fresh prescaler.
    always_comb begin
        auto_s     = 1'b0;
        div_last_s = {PW{1'b0}};
        case (mode_sync_r)
            MODE_SLOW: begin
                auto_s     = 1'b1;
                div_last_s = SLOW_LAST;
            end
            MODE_FAST: begin
                auto_s     = 1'b1;
                div_last_s = FAST_LAST;
            end
            default: begin
                auto_s     = 1'b0;
                div_last_s = {PW{1'b0}};
            end
        endcase
        mode_change_s = (mode_t'(mode_meta_r) != mode_sync_r);
        presc_wrap_s  = auto_s && !mode_change_s && (presc_r == div_last_s);
        step_rise_s   = (mode_sync_r == MODE_STEP) && btn_level_r && !btn_level_prev_r;
        req_s         = presc_wrap_s || step_rise_s;
    end

    // Two-flop synchronizers for the asynchronous switch and button inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_meta_r <= 2'b00;
            mode_sync_r <= MODE_HALT;
            btn_meta_r  <= 1'b0;
            btn_sync_r  <= 1'b0;
        end else begin
            mode_meta_r <= mode;
            mode_sync_r <= mode_t'(mode_meta_r);
            btn_meta_r  <= step_btn;
            btn_sync_r  <= btn_meta_r;
        end
    end

    // Debouncer: accepts the new level on the cycle the stable count would reach the limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            db_cnt_r         <= {DW{1'b0}};
            btn_level_r      <= 1'b0;
            btn_level_prev_r <= 1'b0;
        end else begin
            btn_level_prev_r <= btn_level_r;
            if (btn_sync_r == btn_level_r) begin
                db_cnt_r <= {DW{1'b0}};
            end else if (db_cnt_r == DB_LAST) begin
                btn_level_r <= btn_sync_r;
                db_cnt_r    <= {DW{1'b0}};
            end else begin
                db_cnt_r <= db_cnt_r + DW'(1);
            end
        end
    end

    // Auto-run prescaler.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_r <= {PW{1'b0}};
        end else if (mode_change_s || !auto_s || (presc_r == div_last_s)) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Registered advance pulse with heartbeat and step count.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_en_r   <= 1'b0;
            beat_r     <= 1'b0;
            step_cnt_r <= 8'd0;
        end else begin
            cpu_en_r <= req_s;
            if (req_s) begin
                beat_r     <= ~beat_r;
                step_cnt_r <= step_cnt_r + 8'd1;
            end
        end
    end

    assign cpu_en   = cpu_en_r;
    assign beat     = beat_r;
    assign step_cnt = step_cnt_r;

endmodule

// File: tb/tb_td4_clock_ctrl.sv
// Scoreboard bench for td4_clock_ctrl: expected pulses (edge, count, beat) are queued
// as stimulus is applied and matched against every cpu_en pulse the DUT produces.
module tb_td4_clock_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       step_btn;
    logic       cpu_en;
    logic       beat;
    logic [7:0] step_cnt;

    typedef struct {
        int         edge_n;
        logic [7:0] cnt;
        logic       beat;
    } pulse_t;

    pulse_t     exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         base  = 0;
    logic [7:0] model_cnt  = 8'd0;
    logic       model_beat = 1'b0;

    td4_clock_ctrl #(
        .SLOW_DIV        (10),
        .FAST_DIV        (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clock    (clk),
        .reset    (reset),
        .mode     (mode),
        .step_btn (step_btn),
        .cpu_en   (cpu_en),
        .beat     (beat),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push_abs(input int edge_abs);
        pulse_t p;
        model_cnt  = model_cnt + 8'd1;
        model_beat = ~model_beat;
        p.edge_n   = edge_abs;
        p.cnt      = model_cnt;
        p.beat     = model_beat;
        exp_q.push_back(p);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int rel);
        while (cyc < base + rel) step(1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            step(1);
            chk("rst_cpu_en", cpu_en, 0);
            chk("rst_cnt", step_cnt, 0);
            chk("rst_beat", beat, 0);
        end
        reset      = 1'b0;
        base       = cyc;
        model_cnt  = 8'd0;
        model_beat = 1'b0;
    endtask

    // Pulse monitor: every observed cpu_en must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        pulse_t e;
        if (cpu_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("extra_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_edge", cyc, e.edge_n);
                chk("pulse_cnt", int'(step_cnt), int'(e.cnt));
                chk("pulse_beat", int'(beat), int'(e.beat));
            end
        end
    end

    initial begin
        reset    = 1'b1;
        mode     = 2'b10;
        step_btn = 1'b0;

        // Reset then fast mode: pulses after edges 6, 10, 14, 18.
        do_reset(3);
        for (int i = 0; i < 4; i++) push_abs(base + 6 + 4 * i);
        step_to(19);
        mode = 2'b00;
        step_to(30);
        chk("s1_missing", exp_q.size(), 0);
        chk("s1_cnt", step_cnt, 4);
        chk("s1_beat", beat, 0);

        // Slow to fast switch after two slow pulses.
        mode = 2'b01;
        do_reset(2);
        push_abs(base + 12);
        push_abs(base + 22);
        step_to(22);
        mode = 2'b10;
        push_abs(base + 28);
        push_abs(base + 32);
        push_abs(base + 36);
        step_to(37);
        mode = 2'b00;
        step_to(45);
        chk("s2_missing", exp_q.size(), 0);
        chk("s2_cnt", step_cnt, 5);

        // Manual step with bounce, then a clean hold and release.
        mode = 2'b11;
        do_reset(2);
        step_to(4);
        step_btn = 1'b1; step(1);
        step_btn = 1'b0; step(1);
        step_btn = 1'b1; step(1);
        step_btn = 1'b0; step(1);
        step_btn = 1'b1;
        push_abs(cyc + 1 + 5);
        step(10);
        step_btn = 1'b0;
        step(10);
        chk("s3_missing", exp_q.size(), 0);
        chk("s3_cnt", step_cnt, 1);
        chk("s3_beat", beat, 1);

        // Halt ignores a press; entering manual with the button held gives no pulse.
        mode = 2'b00;
        step(4);
        step_btn = 1'b1; step(8);
        step_btn = 1'b0; step(10);
        chk("s4_halt_cnt", step_cnt, 1);
        step_btn = 1'b1; step(8);
        mode = 2'b11;    step(10);
        chk("s4_held_cnt", step_cnt, 1);
        step_btn = 1'b0; step(8);
        step_btn = 1'b1;
        push_abs(cyc + 1 + 5);
        step(8);
        step_btn = 1'b0; step(8);
        chk("s4_missing", exp_q.size(), 0);
        chk("s4_cnt", step_cnt, 2);
        chk("s4_beat", beat, 0);

        // Wrap after 256 fast pulses, one more pulse, then reset just before the next.
        mode = 2'b10;
        do_reset(2);
        for (int i = 0; i < 257; i++) push_abs(base + 6 + 4 * i);
        step_to(6 + 4 * 255);
        chk("s5_wrap_cnt", step_cnt, 0);
        chk("s5_wrap_beat", beat, 0);
        step_to(6 + 4 * 256);
        chk("s5_post_cnt", step_cnt, 1);
        step_to(6 + 4 * 256 + 3);
        reset = 1'b1;
        step(1);
        chk("s5_rst_cpu_en", cpu_en, 0);
        chk("s5_rst_cnt", step_cnt, 0);
        chk("s5_rst_beat", beat, 0);
        reset = 1'b0;
        step(3);
        chk("s5_missing", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
